// File: rtl/factorial_pkg.sv
// factorial_pkg
// Shared definitions for the sequential factorial engine.
//   fact_state_t  : controller states (IDLE, CALC, DONE)
//   FACT_N_W      : default operand width
//   FACT_RES_W    : default result width
//   fact_prod_w() : width of the untruncated acc*cnt product
package factorial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fact_state_t;

  localparam int FACT_N_W   = 3;
  localparam int FACT_RES_W = 16;

  // The counter is one bit wider than the operand, so a full product needs
  // RES_W bits for the accumulator plus N_W+1 bits for the counter.
  function automatic int fact_prod_w(input int res_w, input int n_w);
    return res_w + n_w + 1;
  endfunction

endpackage

// File: rtl/factorial_mul_step.sv
// factorial_mul_step
// One combinational multiply step of the factorial loop.
// Ports:
//   acc  in   RES_W  current accumulator
//   cnt  in   N_W+1  current loop counter
//   prod out  RES_W  acc*cnt truncated to RES_W bits
//   ovf  out  1      1 when the full product does not fit in RES_W bits
module factorial_mul_step
  import factorial_pkg::*;
#(
  parameter int N_W   = FACT_N_W,
  parameter int RES_W = FACT_RES_W
) (
  input  logic [RES_W-1:0] acc,
  input  logic [N_W:0]     cnt,
  output logic [RES_W-1:0] prod,
  output logic             ovf
);

  localparam int PROD_W = fact_prod_w(RES_W, N_W);

  logic [PROD_W-1:0] full;

  // Multiply at full width first, then split the product into the kept low
  // part and an overflow indication built from every bit that gets dropped.
  always_comb begin
    full = PROD_W'(acc) * PROD_W'(cnt);
    prod = full[RES_W-1:0];
    ovf  = |full[PROD_W-1:RES_W];
  end

endmodule

// File: rtl/factorial_seq_ctrl.sv
// factorial_seq_ctrl
// Sequential factorial engine: takes n on a valid/ready input, computes n!
// with one multiply per clock and presents the result with a sticky overflow
// flag on a valid/ready output. Only one operand is ever in flight.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand offered
//   in_ready   out  1      engine idle and able to accept
//   in_num     in   N_W    operand n
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   out_fact   out  RES_W  n! mod 2**RES_W
//   out_ovf    out  1      some partial product exceeded RES_W bits
//   busy       out  1      computing or holding a result
module factorial_seq_ctrl
  import factorial_pkg::*;
#(
  parameter int N_W   = FACT_N_W,
  parameter int RES_W = FACT_RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_fact,
  output logic             out_ovf,
  output logic             busy
);

  fact_state_t state, next_state;

  logic [RES_W-1:0] acc;
  logic [N_W:0]     cnt;
  logic [N_W-1:0]   n_r;
  logic             ovf_r;

  logic [RES_W-1:0] step_prod;
  logic             step_ovf;
  logic             calc_done;

  // The counter carries an extra bit so that counting past the largest
  // operand does not wrap back to zero and restart the loop.
  assign calc_done = (cnt > {1'b0, n_r});

  factorial_mul_step #(
    .N_W   (N_W),
    .RES_W (RES_W)
  ) u_mul_step (
    .acc  (acc),
    .cnt  (cnt),
    .prod (step_prod),
    .ovf  (step_ovf)
  );

  // Next-state and handshake decode. Results are presented straight from
  // the accumulator and overflow registers, so they stay constant for as
  // long as DONE is held waiting for the consumer. Returning to IDLE takes
  // a full cycle, so a new operand is never accepted on the same edge that
  // a result is taken.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (calc_done) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; a reset in any state abandons the current operand.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Datapath registers. An accepted operand seeds acc=1, cnt=1, then every
  // CALC cycle folds in one more factor until the counter passes n. The
  // overflow flag is sticky: once any step drops bits the result is marked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      n_r   <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_r   <= in_num;
            acc   <= RES_W'(1);
            cnt   <= (N_W+1)'(1);
            ovf_r <= 1'b0;
          end
        end
        CALC: begin
          if (!calc_done) begin
            acc   <= step_prod;
            ovf_r <= ovf_r | step_ovf;
            cnt   <= cnt + (N_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_fact = acc;
  assign out_ovf  = ovf_r;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// tb_factorial_seq_ctrl
// Directed bench for factorial_seq_ctrl. Drives inputs on the falling edge
// and samples outputs on the falling edge. Instance dut_a uses the default
// 3-bit operand; dut_b uses a 4-bit operand to reach overflowing results.
module tb_factorial_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a, busy_a;
  logic [2:0]  in_num_a;
  logic [15:0] out_fact_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b, busy_b;
  logic [3:0]  in_num_b;
  logic [15:0] out_fact_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  factorial_seq_ctrl dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_num    (in_num_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_fact  (out_fact_a),
    .out_ovf   (out_ovf_a),
    .busy      (busy_a)
  );

  factorial_seq_ctrl #(.N_W(4), .RES_W(16)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_num    (in_num_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_fact  (out_fact_b),
    .out_ovf   (out_ovf_b),
    .busy      (busy_b)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d", tag, observed, observed, expected);
    end
  endtask

  // Offer one operand on the chosen instance and return on the falling edge
  // right after the accepting clock edge.
  task automatic applyStimulus(input bit sel, input int n);
    @(negedge clk);
    checkOutput(sel ? "b_accept_ready" : "a_accept_ready",
                sel ? in_ready_b : in_ready_a, 1);
    if (sel) begin
      in_valid_b = 1'b1;
      in_num_b   = 4'(n);
    end else begin
      in_valid_a = 1'b1;
      in_num_a   = 3'(n);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  // Count clock edges until out_valid shows up, bounded so a dead engine
  // still lets the run reach its summary.
  task automatic waitResult(input bit sel, output int cycles);
    cycles = 0;
    while (((sel ? out_valid_b : out_valid_a) !== 1'b1) && cycles < 40) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
  endtask

  // Take the presented result and confirm the engine goes back to idle.
  task automatic takeResult(input bit sel, input string tag);
    if (sel) out_ready_b = 1'b1;
    else     out_ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    checkOutput({tag, "_idle_valid"}, sel ? out_valid_b : out_valid_a, 0);
    checkOutput({tag, "_idle_ready"}, sel ? in_ready_b : in_ready_a, 1);
    checkOutput({tag, "_idle_busy"},  sel ? busy_b : busy_a, 0);
  endtask

  // Full transaction: accept, latency, result, overflow, handshake.
  task automatic runOperand(input bit sel, input int n, input int exp_fact,
                            input bit exp_ovf, input string tag);
    int cycles;
    applyStimulus(sel, n);
    waitResult(sel, cycles);
    checkOutput({tag, "_latency"}, cycles, n + 1);
    checkOutput({tag, "_valid"}, sel ? out_valid_b : out_valid_a, 1);
    checkOutput({tag, "_fact"},  sel ? out_fact_b : out_fact_a, exp_fact);
    checkOutput({tag, "_ovf"},   sel ? out_ovf_b : out_ovf_a, exp_ovf);
    takeResult(sel, tag);
  endtask

  // Confirm nothing is produced after an abort or an ignored request.
  task automatic checkQuiet(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_no_result"}, {busy_a, out_valid_a}, 2'b00);
    end
  endtask

  initial begin
    int cycles;
    logic [15:0] held;

    rst_n       = 1'b0;
    in_valid_a  = 1'b0;
    in_valid_b  = 1'b0;
    in_num_a    = '0;
    in_num_b    = '0;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready",  in_ready_a, 1);
    checkOutput("rst_out_valid", out_valid_a, 0);
    checkOutput("rst_out_fact",  out_fact_a, 0);
    checkOutput("rst_out_ovf",   out_ovf_a, 0);
    checkOutput("rst_busy",      busy_a, 0);
    checkOutput("rst_b_ready",   in_ready_b, 1);
    rst_n = 1'b1;

    // Basic operands, including both trivial ones
    runOperand(0, 5, 120, 0, "n5");
    runOperand(0, 0, 1, 0, "n0");
    runOperand(0, 1, 1, 0, "n1");
    runOperand(0, 3, 6, 0, "n3");

    // Largest 3-bit operand with the consumer stalling for 10 cycles
    applyStimulus(0, 7);
    waitResult(0, cycles);
    checkOutput("n7_latency", cycles, 8);
    checkOutput("n7_fact", out_fact_a, 5040);
    held = out_fact_a;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("n7_hold_fact",  out_fact_a, 5040);
      checkOutput("n7_hold_valid", out_valid_a, 1);
      checkOutput("n7_hold_ready", in_ready_a, 0);
    end
    checkOutput("n7_hold_ovf", out_ovf_a, 0);
    takeResult(0, "n7");

    // Wider operand: last non-overflowing and first overflowing result
    runOperand(1, 8, 40320, 0, "b_n8");
    runOperand(1, 9, 35200, 1, "b_n9");
    runOperand(1, 2, 2, 0, "b_n2");

    // Request during CALC is ignored, not queued
    applyStimulus(0, 6);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ign_ready", in_ready_a, 0);
    checkOutput("ign_busy",  busy_a, 1);
    in_valid_a = 1'b1;
    in_num_a   = 3'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    waitResult(0, cycles);
    checkOutput("ign_latency", cycles, 5);
    checkOutput("ign_fact", out_fact_a, 720);
    checkOutput("ign_ovf",  out_ovf_a, 0);
    takeResult(0, "ign");
    checkQuiet("ign", 8);

    // Reset in the middle of CALC (n=6, counter at 3, acc=2)
    applyStimulus(0, 6);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("abort_mid_acc", out_fact_a, 2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_ready", in_ready_a, 1);
    checkOutput("abort_valid", out_valid_a, 0);
    checkOutput("abort_acc",   out_fact_a, 0);
    checkOutput("abort_busy",  busy_a, 0);
    checkQuiet("abort", 8);
    runOperand(0, 4, 24, 0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
